// File: rtl/anode_scanner.sv
// anode_scanner: rotating active-low anode select for a four-digit
// seven-segment display. Each digit owns a slot of SLOT_CYCLES clocks. The
// first BLANK_CYCLES of every slot keep all anodes off so segment data can
// settle without ghosting. Enable masks individual digits without touching
// slot timing. Every output comes straight from a flop.
module anode_scanner #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Enable,
  output logic [3:0] Select,
  output logic [1:0] DigitIndex,
  output logic       ScanTick
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] count, count_nxt;
  logic [1:0]    index, index_nxt;
  logic          wrap, blank_nxt;
  logic [3:0]    select_nxt;

  // Next slot position: the counter wraps at the slot end and only then
  // moves the digit index on.
  always_comb begin
    wrap      = (count == LAST);
    count_nxt = wrap ? '0 : count + 1'b1;
    index_nxt = wrap ? index + 2'd1 : index;
  end

  // The blanking phase is derived from the counter; with no blanking
  // configured it never occurs and adjacent one-hot codes follow directly.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank_nxt = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
      assign blank_nxt = (count_nxt < BLANK);
    end
  endgenerate

  // Anode code for the next cycle: all off while blanking or when the
  // digit is masked, otherwise a single low bit for the digit.
  always_comb begin
    select_nxt = 4'b1111;
    if (!blank_nxt && Enable[index_nxt])
      select_nxt = ~(4'b0001 << index_nxt);
  end

  // Scan state and registered outputs; reset parks on digit 0, all off.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count      <= '0;
      index      <= 2'd0;
      Select     <= 4'b1111;
      DigitIndex <= 2'd0;
      ScanTick   <= 1'b0;
    end else begin
      count      <= count_nxt;
      index      <= index_nxt;
      Select     <= select_nxt;
      DigitIndex <= index_nxt;
      ScanTick   <= wrap;
    end
  end

endmodule
